// File: rtl/bgpu_pkg.sv
// Shared types for the warp-level issue path.
// Latency: none (types only).
// Backpressure: n/a.
package bgpu_pkg;

  // Dispatch handshake state of the wait buffer.
  typedef enum logic [0:0] {
    WB_IDLE  = 1'b0,
    WB_OFFER = 1'b1
  } wait_buffer_state_e;

endpackage

// File: rtl/wait_buffer_age_matrix.sv
// Age matrix over the wait-buffer slots: records relative insertion order and picks the oldest requester.
// Latency: order update takes effect the cycle after an insert; oldest-selection is combinational.
// Backpressure: none; the owner decides when an insert happens.
module wait_buffer_age_matrix #(
  parameter int unsigned Size     = 4,
  parameter int unsigned IdxWidth = $clog2(Size)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                insert_i,
  input  logic [IdxWidth-1:0] insert_idx_i,
  input  logic [Size-1:0]     valid_i,
  input  logic [Size-1:0]     req_i,
  output logic [Size-1:0]     oldest_oh_o,
  output logic [IdxWidth-1:0] oldest_idx_o
);

  // older_q[i][j] = 1 means slot i was filled before slot j.
  logic [Size-1:0][Size-1:0] older_q;

  // A new entry is younger than every currently valid entry and older than nothing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      older_q <= '0;
    end else if (insert_i) begin
      for (int j = 0; j < Size; j++) begin
        older_q[j][insert_idx_i] <= valid_i[j];
      end
      for (int j = 0; j < Size; j++) begin
        older_q[insert_idx_i][j] <= 1'b0;
      end
    end
  end

  // A requester wins when no other requester is older than it.
  always_comb begin
    logic blocked;
    blocked     = 1'b0;
    oldest_oh_o = '0;
    for (int i = 0; i < Size; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < Size; j++) begin
        if (j != i && req_i[j] && older_q[j][i]) begin
          blocked = 1'b1;
        end
      end
      oldest_oh_o[i] = req_i[i] && !blocked;
    end
  end

  // Encode the one-hot winner into a slot index.
  always_comb begin
    oldest_idx_o = '0;
    for (int i = 0; i < Size; i++) begin
      if (oldest_oh_o[i]) begin
        oldest_idx_o = IdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/wait_buffer.sv
// Per-warp out-of-order wait buffer: holds decoded instructions until their operands are woken, dispatches oldest ready first.
// Latency: ready insert -> dispatch_valid_o two cycles later; wakeup -> dispatch_valid_o two cycles later when idle.
// Backpressure: offered instruction is frozen while dispatch_ready_i is low; inserts are dropped when no slot is free.
module wait_buffer #(
  parameter int unsigned NumTags         = 8,
  parameter int unsigned TagWidth        = $clog2(NumTags),
  parameter int unsigned OperandsPerInst = 2,
  parameter int unsigned WaitBufferSize  = 4,
  parameter int unsigned InstWidth       = 32
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  output logic                                     space_available_o,
  output logic                                     empty_o,
  input  logic                                     insert_i,
  input  logic [TagWidth-1:0]                      tag_i,
  input  logic [InstWidth-1:0]                     inst_i,
  input  logic [OperandsPerInst-1:0]               operands_ready_i,
  input  logic [OperandsPerInst-1:0][TagWidth-1:0] operands_tag_i,
  input  logic                                     eu_valid_i,
  input  logic [TagWidth-1:0]                      eu_tag_i,
  output logic                                     dispatch_valid_o,
  input  logic                                     dispatch_ready_i,
  output logic [TagWidth-1:0]                      dispatch_tag_o,
  output logic [InstWidth-1:0]                     dispatch_inst_o
);

  import bgpu_pkg::*;

  localparam int unsigned IdxWidth = $clog2(WaitBufferSize);

  typedef logic [TagWidth-1:0]  tag_t;
  typedef logic [InstWidth-1:0] inst_t;

  typedef struct packed {
    logic                                     valid;
    tag_t                                     tag;
    inst_t                                    inst;
    logic [OperandsPerInst-1:0]               op_ready;
    logic [OperandsPerInst-1:0][TagWidth-1:0] op_tag;
  } entry_t;

  entry_t                    entries_q [WaitBufferSize];
  entry_t                    ins_entry;
  wait_buffer_state_e        state_q;
  logic [IdxWidth-1:0]       sel_q;
  logic [WaitBufferSize-1:0] valid_vec;
  logic [WaitBufferSize-1:0] cand_vec;
  logic [WaitBufferSize-1:0] req_vec;
  logic [WaitBufferSize-1:0] oldest_oh;
  logic [IdxWidth-1:0]       oldest_idx;
  logic [IdxWidth-1:0]       free_idx;
  logic                      oldest_valid;
  logic                      insert_fire;
  logic                      handshake;

  // Occupancy and readiness seen from registered state only.
  always_comb begin
    valid_vec = '0;
    cand_vec  = '0;
    for (int i = 0; i < WaitBufferSize; i++) begin
      valid_vec[i] = entries_q[i].valid;
      cand_vec[i]  = entries_q[i].valid && (&entries_q[i].op_ready);
    end
  end

  // Lowest-index free slot; scanning downward lets the lowest one win.
  always_comb begin
    free_idx = '0;
    for (int i = WaitBufferSize - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        free_idx = IdxWidth'(i);
      end
    end
  end

  assign space_available_o = !(&valid_vec);
  assign empty_o           = !(|valid_vec);
  assign insert_fire       = insert_i && space_available_o;
  assign handshake         = (state_q == WB_OFFER) && dispatch_ready_i;

  // The entry being offered is excluded so a handshake can chain straight to the next candidate.
  always_comb begin
    req_vec = cand_vec;
    if (state_q == WB_OFFER) begin
      req_vec[sel_q] = 1'b0;
    end
  end

  wait_buffer_age_matrix #(
    .Size     (WaitBufferSize),
    .IdxWidth (IdxWidth)
  ) i_age_matrix (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .insert_i     (insert_fire),
    .insert_idx_i (free_idx),
    .valid_i      (valid_vec),
    .req_i        (req_vec),
    .oldest_oh_o  (oldest_oh),
    .oldest_idx_o (oldest_idx)
  );

  assign oldest_valid = |oldest_oh;

  // New entry image; a writeback in the same cycle already counts as ready.
  always_comb begin
    ins_entry       = '0;
    ins_entry.valid = 1'b1;
    ins_entry.tag   = tag_i;
    ins_entry.inst  = inst_i;
    ins_entry.op_tag = operands_tag_i;
    for (int o = 0; o < OperandsPerInst; o++) begin
      ins_entry.op_ready[o] = operands_ready_i[o] ||
                              (eu_valid_i && (eu_tag_i == operands_tag_i[o]));
    end
  end

  // Entry array: wakeup snooping, freeing on handshake, filling on insert.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < WaitBufferSize; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      for (int i = 0; i < WaitBufferSize; i++) begin
        if (eu_valid_i) begin
          for (int o = 0; o < OperandsPerInst; o++) begin
            if (entries_q[i].op_tag[o] == eu_tag_i) begin
              entries_q[i].op_ready[o] <= 1'b1;
            end
          end
        end
        if (handshake && (sel_q == IdxWidth'(i))) begin
          entries_q[i].valid <= 1'b0;
        end
        if (insert_fire && (free_idx == IdxWidth'(i))) begin
          entries_q[i] <= ins_entry;
        end
      end
    end
  end

  // Dispatch handshake: latch the oldest candidate, hold it until accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WB_IDLE;
      sel_q   <= '0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (oldest_valid) begin
            sel_q   <= oldest_idx;
            state_q <= WB_OFFER;
          end
        end
        WB_OFFER: begin
          if (dispatch_ready_i) begin
            if (oldest_valid) begin
              sel_q <= oldest_idx;
            end else begin
              state_q <= WB_IDLE;
            end
          end
        end
        default: begin
          state_q <= WB_IDLE;
        end
      endcase
    end
  end

  // Outputs come from the state register and the selected entry; zero when nothing is offered.
  always_comb begin
    dispatch_valid_o = (state_q == WB_OFFER);
    dispatch_tag_o   = '0;
    dispatch_inst_o  = '0;
    if (dispatch_valid_o) begin
      dispatch_tag_o  = entries_q[sel_q].tag;
      dispatch_inst_o = entries_q[sel_q].inst;
    end
  end

  // Flag inserts attempted with no free slot; such a request is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && insert_i) begin
      assert (space_available_o) else $warning("wait_buffer: insert while full ignored");
    end
  end

endmodule

// File: tb/tb_wait_buffer.sv
module tb_wait_buffer;

  localparam int Size = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        space_available_o;
  logic        empty_o;
  logic        insert_i;
  logic [2:0]  tag_i;
  logic [31:0] inst_i;
  logic [1:0]  operands_ready_i;
  logic [1:0][2:0] operands_tag_i;
  logic        eu_valid_i;
  logic [2:0]  eu_tag_i;
  logic        dispatch_valid_o;
  logic        dispatch_ready_i;
  logic [2:0]  dispatch_tag_o;
  logic [31:0] dispatch_inst_o;

  always #5 clk_i = ~clk_i;

  wait_buffer #(
    .NumTags         (8),
    .OperandsPerInst (2),
    .WaitBufferSize  (Size),
    .InstWidth       (32)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .space_available_o (space_available_o),
    .empty_o           (empty_o),
    .insert_i          (insert_i),
    .tag_i             (tag_i),
    .inst_i            (inst_i),
    .operands_ready_i  (operands_ready_i),
    .operands_tag_i    (operands_tag_i),
    .eu_valid_i        (eu_valid_i),
    .eu_tag_i          (eu_tag_i),
    .dispatch_valid_o  (dispatch_valid_o),
    .dispatch_ready_i  (dispatch_ready_i),
    .dispatch_tag_o    (dispatch_tag_o),
    .dispatch_inst_o   (dispatch_inst_o)
  );

  // Reference model: instructions kept in age order (front = oldest).
  typedef struct {
    int          id;
    logic [2:0]  tag;
    logic [31:0] inst;
    logic [1:0]  rdy;
    logic [1:0][2:0] otag;
  } m_entry_t;

  m_entry_t mq[$];
  bit       off_v   = 1'b0;
  int       off_id  = 0;
  int       next_id = 0;
  int       n_checks = 0;
  int       n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", name, obs, exp);
  endtask

  task automatic chk1(input string name, input logic obs, input logic exp);
    chk(name, 32'(obs), 32'(exp));
  endtask

  function automatic int find_id(input int id);
    for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
    return -1;
  endfunction

  // One clock edge of the reference behaviour, using pre-edge state and current inputs.
  task automatic model_step();
    int      pre_size;
    bit      hs;
    bit      found;
    int      nid;
    m_entry_t e;
    pre_size = mq.size();
    if (rst_i) begin
      mq.delete();
      off_v = 1'b0;
      return;
    end
    hs = off_v && dispatch_ready_i;
    if (!off_v || hs) begin
      found = 1'b0;
      nid   = 0;
      foreach (mq[i]) begin
        if (!found && (&mq[i].rdy) && !(hs && mq[i].id == off_id)) begin
          found = 1'b1;
          nid   = mq[i].id;
        end
      end
      if (hs) mq.delete(find_id(off_id));
      off_v  = found;
      off_id = nid;
    end
    if (eu_valid_i) begin
      foreach (mq[i]) begin
        for (int o = 0; o < 2; o++) if (mq[i].otag[o] == eu_tag_i) mq[i].rdy[o] = 1'b1;
      end
    end
    if (insert_i && pre_size < Size) begin
      e.id   = next_id++;
      e.tag  = tag_i;
      e.inst = inst_i;
      e.otag = operands_tag_i;
      for (int o = 0; o < 2; o++)
        e.rdy[o] = operands_ready_i[o] || (eu_valid_i && eu_tag_i == operands_tag_i[o]);
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    int k;
    @(posedge clk_i);
    model_step();
    #1;
    chk1("m_valid", dispatch_valid_o, off_v);
    if (off_v) begin
      k = find_id(off_id);
      chk("m_tag", 32'(dispatch_tag_o), 32'(mq[k].tag));
      chk("m_inst", dispatch_inst_o, mq[k].inst);
    end
    chk1("m_space", space_available_o, mq.size() < Size);
    chk1("m_empty", empty_o, mq.size() == 0);
  endtask

  task automatic idle_inputs();
    insert_i         = 1'b0;
    tag_i            = '0;
    inst_i           = '0;
    operands_ready_i = '0;
    operands_tag_i   = '0;
    eu_valid_i       = 1'b0;
    eu_tag_i         = '0;
  endtask

  task automatic ins(input logic [2:0] t, input logic [31:0] d, input logic [1:0] r, input logic [5:0] ot);
    insert_i         = 1'b1;
    tag_i            = t;
    inst_i           = d;
    operands_ready_i = r;
    operands_tag_i   = ot;
  endtask

  task automatic eu(input logic [2:0] t);
    eu_valid_i = 1'b1;
    eu_tag_i   = t;
  endtask

  initial begin
    idle_inputs();
    dispatch_ready_i = 1'b1;
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    chk1("rst_valid", dispatch_valid_o, 1'b0);
    chk("rst_tag", 32'(dispatch_tag_o), 32'd0);
    chk("rst_inst", dispatch_inst_o, 32'd0);
    chk1("rst_space", space_available_o, 1'b1);
    chk1("rst_empty", empty_o, 1'b1);

    // Ready insert: offered two cycles later, gone the cycle after.
    ins(3'd3, 32'hA3, 2'b11, 6'o00); tick(); idle_inputs();
    chk1("tp1_t1_valid", dispatch_valid_o, 1'b0);
    chk1("tp1_t1_empty", empty_o, 1'b0);
    tick();
    chk1("tp1_valid", dispatch_valid_o, 1'b1);
    chk("tp1_tag", 32'(dispatch_tag_o), 32'd3);
    tick();
    chk1("tp1_empty", empty_o, 1'b1);

    // Wakeup on tags 5 then 6.
    ins(3'd1, 32'hB1, 2'b00, {3'd6, 3'd5}); tick(); idle_inputs();
    chk1("tp2_wait_a", dispatch_valid_o, 1'b0);
    tick();
    eu(3'd5); tick(); idle_inputs();
    chk1("tp2_wait_b", dispatch_valid_o, 1'b0);
    tick();
    eu(3'd6); tick(); idle_inputs();
    chk1("tp2_wait_c", dispatch_valid_o, 1'b0);
    tick();
    chk1("tp2_valid", dispatch_valid_o, 1'b1);
    chk("tp2_tag", 32'(dispatch_tag_o), 32'd1);
    tick();
    chk1("tp2_empty", empty_o, 1'b1);

    // Writeback in the insert cycle counts as ready.
    ins(3'd5, 32'hC5, 2'b00, {3'd2, 3'd2}); eu(3'd2); tick(); idle_inputs();
    chk1("tp3_early", dispatch_valid_o, 1'b0);
    tick();
    chk1("tp3_valid", dispatch_valid_o, 1'b1);
    chk("tp3_tag", 32'(dispatch_tag_o), 32'd5);
    tick();

    // Oldest first, back-to-back.
    dispatch_ready_i = 1'b0;
    ins(3'd4, 32'hD4, 2'b00, 6'o00); tick();
    ins(3'd7, 32'hD7, 2'b00, 6'o00); tick(); idle_inputs();
    eu(3'd0); tick(); idle_inputs();
    tick();
    chk("tp4_first", 32'(dispatch_tag_o), 32'd4);
    dispatch_ready_i = 1'b1;
    tick();
    chk1("tp4_b2b_valid", dispatch_valid_o, 1'b1);
    chk("tp4_second", 32'(dispatch_tag_o), 32'd7);
    tick();
    chk1("tp4_empty", empty_o, 1'b1);

    // Offer frozen while stalled even when an older entry wakes.
    dispatch_ready_i = 1'b0;
    ins(3'd2, 32'hE2, 2'b00, {3'd5, 3'd5}); tick();
    ins(3'd7, 32'hE7, 2'b11, 6'o00); tick(); idle_inputs();
    tick();
    chk("tp4_hold_tag0", 32'(dispatch_tag_o), 32'd7);
    eu(3'd5); tick(); idle_inputs();
    for (int c = 0; c < 3; c++) begin
      chk("tp4_hold_tag", 32'(dispatch_tag_o), 32'd7);
      chk("tp4_hold_inst", dispatch_inst_o, 32'hE7);
      tick();
    end
    dispatch_ready_i = 1'b1;
    tick();
    chk("tp4_after_hold", 32'(dispatch_tag_o), 32'd2);
    tick();
    chk1("tp4_hold_empty", empty_o, 1'b1);

    // Full buffer and dropped overflow insert.
    dispatch_ready_i = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      ins(3'(t), 32'hF0 + 32'(t), 2'b00, {3'd3, 3'd3}); tick();
    end
    idle_inputs();
    chk1("tp5_full", space_available_o, 1'b0);
    ins(3'd6, 32'hDEAD, 2'b11, 6'o00); tick(); idle_inputs();
    chk1("tp5_still_full", space_available_o, 1'b0);
    tick();
    chk1("tp5_ovf_no_offer", dispatch_valid_o, 1'b0);
    eu(3'd3); tick(); idle_inputs();
    tick();
    chk("tp5_d1", 32'(dispatch_tag_o), 32'd1);
    dispatch_ready_i = 1'b1;
    tick();
    chk1("tp5_space_back", space_available_o, 1'b1);
    chk("tp5_d2", 32'(dispatch_tag_o), 32'd2);
    tick();
    chk("tp5_d3", 32'(dispatch_tag_o), 32'd3);
    tick();
    chk("tp5_d4", 32'(dispatch_tag_o), 32'd4);
    chk("tp5_d4_inst", dispatch_inst_o, 32'hF4);
    tick();
    chk1("tp5_empty", empty_o, 1'b1);

    // Reset while offering.
    dispatch_ready_i = 1'b0;
    ins(3'd5, 32'h66, 2'b11, 6'o00); tick(); idle_inputs();
    tick();
    chk1("tp6_offer", dispatch_valid_o, 1'b1);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk1("tp6_valid", dispatch_valid_o, 1'b0);
    chk1("tp6_empty", empty_o, 1'b1);
    chk1("tp6_space", space_available_o, 1'b1);
    chk("tp6_tag", 32'(dispatch_tag_o), 32'd0);
    chk("tp6_inst", dispatch_inst_o, 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      insert_i         = (mq.size() < Size) && ($urandom_range(0, 1) == 1);
      tag_i            = 3'($urandom_range(0, 7));
      inst_i           = $urandom;
      operands_ready_i = 2'($urandom_range(0, 3));
      operands_tag_i   = 6'($urandom_range(0, 63));
      eu_valid_i       = ($urandom_range(0, 1) == 1);
      eu_tag_i         = 3'($urandom_range(0, 7));
      dispatch_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    dispatch_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
